// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, register constants and requester ids for the writeback scheduler
package regfile_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic {REQ_ALU, REQ_LD} req_id_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy-bit scoreboard: set on issue, clear on register-file write, hazard stall
import regfile_pkg::*;

module wb_scoreboard (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rd,
  input  logic [REG_AW-1:0]   iss_rs1,
  input  logic [REG_AW-1:0]   iss_rs2,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                iss_stall
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  assign iss_stall = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && !iss_stall && iss_rd != ZERO_REG) set_mask = reg_onehot(iss_rd);
    if (clr_en)                                         clr_mask = reg_onehot(clr_addr);
  end

  // Register 0 is masked out so its busy bit stays a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~reg_onehot(ZERO_REG);
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - ALU/load writeback arbiter with starvation guard and registered write port
// Optional scoreboard enabled by macro REGFILE_WB_SCOREBOARD_EN.
import regfile_pkg::*;

module regfile_wb_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [REG_AW-1:0]   ld_rd,
  input  logic [XLEN-1:0]     ld_data,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_rd,
  input  logic [REG_AW-1:0]   iss_rs1,
  input  logic [REG_AW-1:0]   iss_rs2,
  output logic                iss_stall,
  output logic                write_en,
  output logic [REG_AW-1:0]   write_addr,
  output logic [XLEN-1:0]     write_data,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt;
  logic              grant_vld;
  req_id_e           grant_id;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  // Loads win ties until the ALU has waited LIMIT cycles.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = REQ_LD;
    if (alu_valid && (!ld_valid || starve_cnt == LIMIT)) begin
      grant_vld = 1'b1;
      grant_id  = REQ_ALU;
    end else if (ld_valid) begin
      grant_vld = 1'b1;
      grant_id  = REQ_LD;
    end
  end

  assign alu_ready = rst_n && grant_vld && grant_id == REQ_ALU;
  assign ld_ready  = rst_n && grant_vld && grant_id == REQ_LD;
  assign sel_rd    = (grant_id == REQ_ALU) ? alu_rd   : ld_rd;
  assign sel_data  = (grant_id == REQ_ALU) ? alu_data : ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        starve_cnt <= '0;
    else if (!alu_valid || alu_ready)  starve_cnt <= '0;
    else if (starve_cnt != LIMIT)      starve_cnt <= starve_cnt + 4'd1;
  end

  // Writes to register 0 are accepted and dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= grant_vld && sel_rd != ZERO_REG;
      if (grant_vld) begin
        write_addr <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .clr_en    (write_en),
    .clr_addr  (write_addr),
    .busy_vec  (busy_vec),
    .iss_stall (iss_stall)
  );
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_rd, iss_rs1, iss_rs2};
  assign busy_vec   = '0;
  assign iss_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - directed and randomized self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, iss_valid;
  logic        alu_ready, ld_ready, iss_stall, write_en;
  logic [4:0]  alu_rd, ld_rd, iss_rd, iss_rs1, iss_rs2, write_addr;
  logic [31:0] alu_data, ld_data, write_data, busy_vec;

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  regfile_wb_sched #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
    iss_valid = 0; iss_rd = 0; iss_rs1  = 0; iss_rs2 = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    alu_valid = 1; ld_valid = 1; iss_valid = 1;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({alu_ready, ld_ready, iss_stall, write_en} !== 4'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000", {alu_ready, ld_ready, iss_stall, write_en});
    end
    total++;
    if (write_addr !== 5'd0 || write_data !== 32'd0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", write_addr, write_data, busy_vec);
    end
    drive_idle();
    rst_n = 1;
  endtask

  task automatic test_alu_single();
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    total++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
      bad++; $display("FAIL alu_only_ready got=%b%b exp=10", alu_ready, ld_ready);
    end
    @(negedge clk);
    drive_idle();
    total++;
    if (write_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", write_en, write_addr, write_data);
    end
    #1;
    total++;
    if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      bad++; $display("FAIL idle_ready got=%b%b exp=00", alu_ready, ld_ready);
    end
    @(negedge clk);
    total++;
    if (write_en !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_hold got=%b/%0d/%h exp=0/5/deadbeef", write_en, write_addr, write_data);
    end
  endtask

  task automatic test_starve();
    string exp_seq = "LLLLALLLLAL";
    for (int i = 0; i < exp_seq.len(); i++) begin
      @(negedge clk);
      alu_valid = 1; alu_rd = 5'd9;  alu_data = 32'hA000_0000 + i;
      ld_valid  = 1; ld_rd  = 5'd10; ld_data  = 32'hB000_0000 + i;
      #1;
      total++;
      if ((exp_seq[i] == "A") ? (alu_ready !== 1'b1 || ld_ready !== 1'b0)
                              : (alu_ready !== 1'b0 || ld_ready !== 1'b1)) begin
        bad++; $display("FAIL starve_grant[%0d] got=%b%b exp=%s", i, alu_ready, ld_ready, exp_seq[i]);
      end
    end
    @(negedge clk);
    drive_idle();
    total++;
    if (write_en !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'hB000_000A) begin
      bad++; $display("FAIL starve_last_write got=%b/%0d/%h exp=1/10/b000000a", write_en, write_addr, write_data);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
    #1;
    total++;
    if (ld_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ld_ready got=%b exp=1", ld_ready);
    end
    @(negedge clk);
    drive_idle();
    total++;
    if (write_en !== 1'b0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL zero_write got=%b/%h exp=0/0", write_en, busy_vec);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    iss_valid = 1; iss_rd = 7;
    #1;
    total++;
    if (iss_stall !== 1'b0) begin
      bad++; $display("FAIL issue7_stall got=%b exp=0", iss_stall);
    end
    @(negedge clk);
    iss_rd = 1; iss_rs1 = 7; iss_rs2 = 0;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h7777;
    #1;
    total++;
    if (iss_stall !== SB || busy_vec !== (SB ? 32'h80 : 32'h0)) begin
      bad++; $display("FAIL rs1_hazard got=%b/%h exp=%b/%h", iss_stall, busy_vec, SB, SB ? 32'h80 : 32'h0);
    end
    @(negedge clk);
    ld_valid = 0;
    #1;
    total++;
    if (write_en !== 1'b1 || iss_stall !== SB) begin
      bad++; $display("FAIL ld7_write got=%b/%b exp=1/%b", write_en, iss_stall, SB);
    end
    @(negedge clk);
    #1;
    total++;
    if (iss_stall !== 1'b0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL stall_release got=%b/%h exp=0/0", iss_stall, busy_vec);
    end
    drive_idle();
    @(negedge clk);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    total++;
    if (busy_vec !== 32'd0) begin
      bad++; $display("FAIL sb_clean got=%h exp=0", busy_vec);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    iss_valid = 1; iss_rd = 7;
    @(negedge clk);
    iss_rd = 11;
    @(negedge clk);
    iss_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    @(negedge clk);
    alu_valid = 0;
    total++;
    if (write_en !== 1'b1 || busy_vec !== (SB ? 32'h880 : 32'h0)) begin
      bad++; $display("FAIL pre_reset got=%b/%h exp=1/%h", write_en, busy_vec, SB ? 32'h880 : 32'h0);
    end
    #2;
    alu_valid = 1; ld_valid = 1; iss_valid = 1; iss_rs1 = 7;
    rst_n = 0;
    #1;
    total++;
    if ({alu_ready, ld_ready, iss_stall, write_en} !== 4'b0 || write_addr !== 5'd0 ||
        write_data !== 32'd0 || busy_vec !== 32'd0) begin
      bad++; $display("FAIL async_reset got=%b%b%b%b/%h/%h/%h exp=0", alu_ready, ld_ready, iss_stall,
                      write_en, write_addr, write_data, busy_vec);
    end
    @(negedge clk);
    drive_idle();
    rst_n = 1;
  endtask

  task automatic test_random();
    int          m_cnt  = 0;
    bit          m_wen  = 0;
    bit [4:0]    m_addr = 0;
    bit [31:0]   m_data = 0;
    bit [31:0]   m_busy = 0;
    bit          e_ar, e_lr, e_st;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if (write_en !== m_wen || (m_wen && (write_addr !== m_addr || write_data !== m_data))) begin
        bad++; $display("FAIL rnd_write[%0d] got=%b/%0d/%h exp=%b/%0d/%h", c, write_en, write_addr,
                        write_data, m_wen, m_addr, m_data);
      end
      total++;
      if (busy_vec !== m_busy) begin
        bad++; $display("FAIL rnd_busy[%0d] got=%h exp=%h", c, busy_vec, m_busy);
      end
      alu_valid = ($urandom_range(0, 9) < 7); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 7); ld_rd  = 5'($urandom_range(0, 7)); ld_data  = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd  = 5'($urandom_range(0, 7));
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      #1;
      e_ar = alu_valid && (!ld_valid || m_cnt == LIMIT);
      e_lr = ld_valid && !e_ar;
      e_st = SB && iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
      total++;
      if (alu_ready !== e_ar || ld_ready !== e_lr || iss_stall !== e_st) begin
        bad++; $display("FAIL rnd_ctl[%0d] got=%b%b%b exp=%b%b%b", c, alu_ready, ld_ready, iss_stall,
                        e_ar, e_lr, e_st);
      end
      if (m_wen) m_busy[m_addr] = 1'b0;
      if (SB && iss_valid && !e_st && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (!alu_valid || e_ar) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      if (e_ar) begin
        m_wen = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
      end else if (e_lr) begin
        m_wen = (ld_rd != 0);  m_addr = ld_rd;  m_data = ld_data;
      end else begin
        m_wen = 0;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_starve();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles the ALU requester may wait before it takes priority; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid / alu_ready  input / output  1 / 1  ALU writeback handshake.
REQ-005 alu_rd / alu_data  input  5 / 32  ALU destination register and result.
REQ-006 ld_valid / ld_ready  input / output  1 / 1  load-unit writeback handshake.
REQ-007 ld_rd / ld_data  input  5 / 32  load destination register and loaded data.
REQ-008 iss_valid  input  1  decode presents an instruction for issue.
REQ-009 iss_rd / iss_rs1 / iss_rs2  input  5 each  issuing instruction's destination and source registers.
REQ-010 iss_stall  output  1  issue blocked by hazard.
REQ-011 write_en / write_addr / write_data  output  1 / 5 / 32  register-file write port drive.
REQ-012 busy_vec  output  32  scoreboard state, bit i = register i has a pending write.

Function
REQ-013 A transfer occurs on a requester when valid and ready are both high at posedge clk; at most one ready is high per cycle.
REQ-014 ready is combinational: only one valid → that requester ready; neither valid → both ready low.
REQ-015 Both valid: ld_ready high unless starve_cnt == STARVE_LIMIT, in which case alu_ready high.
REQ-016 starve_cnt (4 bits): increments, saturating at STARVE_LIMIT, when alu_valid && !alu_ready; clears to 0 on an ALU transfer or when alu_valid is low.
REQ-017 Latency is one cycle: a transfer at edge E drives write_en/write_addr/write_data from edge E until edge E+1; with no transfer, write_en is 0 and addr/data hold.
REQ-018 A transfer with rd == 0 is accepted but produces write_en = 0; register 0 is never written.
REQ-019 busy_vec bit 0 is constant 0.
REQ-020 iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]).
REQ-021 iss_valid && !iss_stall && iss_rd != 0 at an edge sets busy[iss_rd].
REQ-022 write_en high at an edge clears busy[write_addr]. A consumer issuing after that edge reads the new value through the registered-read register file.
REQ-023 Set and clear of the same bit in one cycle cannot occur, because the busy bit still stalls issue (REQ-020).
REQ-024 Set and clear of different bits in the same cycle both take effect.
REQ-025 Writebacks to a non-busy register are written normally and leave busy_vec unchanged.

Reset
REQ-026 While rst_n is low, regardless of clk: write_en = 0, write_addr = 0, write_data = 0, busy_vec = 0, starve_cnt = 0, alu_ready = ld_ready = 0, iss_stall = 0.
REQ-027 Reset mid-operation discards in-flight transfers and pending busy bits without a write.
REQ-028 The first transfer can occur at the first posedge after rst_n rises.

Configuration
REQ-029 Macro REGFILE_WB_SCOREBOARD_EN defined: scoreboard present per REQ-019..REQ-025.
REQ-030 Macro REGFILE_WB_SCOREBOARD_EN undefined: no busy storage; busy_vec = 0 and iss_stall = 0 constantly; iss_* inputs are ignored; arbitration and write path are unchanged.

Structure
REQ-031 Shared package regfile_pkg holds XLEN = 32, REG_AW = 5, NUM_REGS = 32, ZERO_REG = 5'd0 and the requester-id enum {REQ_ALU, REQ_LD}.
REQ-032 Sub-module wb_scoreboard holds busy_vec set/clear and the stall compare, and is instantiated only under REGFILE_WB_SCOREBOARD_EN.
REQ-033 Arbitration, starve counter and the write-port register reside in regfile_wb_sched.

Verification
REQ-034 Only alu_valid with rd = 5, data = 0xDEADBEEF → alu_ready = 1; next cycle write_en = 1, write_addr = 5, write_data = 0xDEADBEEF.
REQ-035 Both valid continuously, STARVE_LIMIT = 4 → grants LD, LD, LD, LD, then ALU, then LD again; starve_cnt returns to 0 after the ALU grant.
REQ-036 Load writeback with rd = 0, data = 0x1234 → ld_ready = 1, write_en stays 0 next cycle, busy_vec stays 0.
REQ-037 Issue rd = 7; next cycle iss_rs1 = 7 → iss_stall = 1; load writes rd = 7 → stall deasserts the cycle after write_en; busy_vec[7] = 0.
REQ-038 rst_n pulled low asynchronously with busy_vec = 0x00000880 and write_en = 1 → all outputs 0 immediately, without waiting for clk.
REQ-039 Build without REGFILE_WB_SCOREBOARD_EN, issue rd = 3 then rs1 = 3 → iss_stall = 0 and busy_vec = 0 throughout.
